// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified I/D memory arbiter: state encoding and
// the default starvation limit.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        DATA  = ST_DATA,
        DONE  = ST_DONE
    } arb_state_t;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the arbiter's stall-cycle statistics.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins by default; a starvation limit forces a fetch. Optional stall
// statistics are built when MEM_ARB_PERF_EN is defined.
//
//   state | meaning
//   IDLE  | arbitrate between if_req and dm_req
//   FETCH | fetch access in flight, waiting for mem_ack
//   DATA  | data access in flight, waiting for mem_ack
//   DONE  | owner's valid pulse; requests not evaluated
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_valid,
    output logic             stall_if,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_valid,
    output logic             stall_dm,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] fetch_wait_cnt,
    output logic [WIDTH-1:0] data_wait_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state, state_nxt;
    logic [3:0] starve_cnt;
    logic       grant_dm;
    logic       grant_if;

    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                if (dm_req && !(if_req && (starve_cnt == STARVE_LIM))) begin
                    grant_dm  = 1'b1;
                    state_nxt = DATA;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ack) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    assign mem_req  = (state == FETCH) || (state == DATA);
    assign stall_if = if_req && !if_valid;
    assign stall_dm = dm_req && !dm_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_valid   <= 1'b0;
            dm_valid   <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            if_valid <= (state == FETCH) && mem_ack;
            dm_valid <= (state == DATA) && mem_ack;
            if (grant_dm) begin
                mem_we     <= dm_we;
                mem_addr   <= dm_addr;
                mem_wdata  <= dm_wdata;
                starve_cnt <= if_req ? starve_cnt + 4'd1 : 4'd0;
            end else if (grant_if) begin
                mem_we     <= 1'b0;
                mem_addr   <= if_addr;
                starve_cnt <= 4'd0;
            end
            if ((state == FETCH) && mem_ack) if_rdata <= mem_rdata;
            // a completing write must not disturb the last load result
            if ((state == DATA) && mem_ack && !mem_we) dm_rdata <= mem_rdata;
        end
    end

`ifdef MEM_ARB_PERF_EN
    sat_counter #(.WIDTH(WIDTH)) u_fetch_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_if),
        .count (fetch_wait_cnt)
    );

    sat_counter #(.WIDTH(WIDTH)) u_data_wait (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_dm),
        .count (data_wait_cnt)
    );
`else
    assign fetch_wait_cnt = '0;
    assign data_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run checked against a cycle-timeline reference model and a memory image.
module tb_mem_arbiter;

    localparam int WIDTH      = 32;
    localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_PERF_EN
    localparam logic [31:0] EXP_DWAIT = 32'd6;
`else
    localparam logic [31:0] EXP_DWAIT = 32'd0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             if_req, dm_req, dm_we, mem_ack;
    logic [WIDTH-1:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [WIDTH-1:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [WIDTH-1:0] fetch_wait_cnt, data_wait_cnt;
    logic             if_valid, dm_valid, stall_if, stall_dm, mem_req, mem_we;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.WIDTH(WIDTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_rdata       (if_rdata),
        .if_valid       (if_valid),
        .stall_if       (stall_if),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_rdata       (dm_rdata),
        .dm_valid       (dm_valid),
        .stall_dm       (stall_dm),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .fetch_wait_cnt (fetch_wait_cnt),
        .data_wait_cnt  (data_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges; returns in the first cycle with reset released.
    task automatic do_reset();
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 10;
        if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else n_pass++;
        if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else n_pass++;
        if (mem_addr !== '0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
        if (mem_wdata !== '0) $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); else n_pass++;
        if (if_rdata !== '0) $display("FAIL reset_if_rdata got %h want 0", if_rdata); else n_pass++;
        if (dm_rdata !== '0) $display("FAIL reset_dm_rdata got %h want 0", dm_rdata); else n_pass++;
        if (if_valid !== 1'b0) $display("FAIL reset_if_valid got %b want 0", if_valid); else n_pass++;
        if (dm_valid !== 1'b0) $display("FAIL reset_dm_valid got %b want 0", dm_valid); else n_pass++;
        if (fetch_wait_cnt !== '0) $display("FAIL reset_fetch_cnt got %h want 0", fetch_wait_cnt); else n_pass++;
        if (data_wait_cnt !== '0) $display("FAIL reset_data_cnt got %h want 0", data_wait_cnt); else n_pass++;
    endtask

    task automatic test_single_fetch();
        do_reset();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        #1;
        n_checks++; if (stall_if !== 1'b1) $display("FAIL sf_stall_c0 got %b want 1", stall_if); else n_pass++;
        cyc();
        n_checks += 4;
        if (mem_req !== 1'b1) $display("FAIL sf_mem_req got %b want 1", mem_req); else n_pass++;
        if (mem_addr !== 32'h40) $display("FAIL sf_mem_addr got %h want 40", mem_addr); else n_pass++;
        if (mem_we !== 1'b0) $display("FAIL sf_mem_we got %b want 0", mem_we); else n_pass++;
        if (stall_if !== 1'b1) $display("FAIL sf_stall_c1 got %b want 1", stall_if); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
        cyc();
        mem_ack = 1'b0;
        n_checks += 4;
        if (if_valid !== 1'b1) $display("FAIL sf_if_valid got %b want 1", if_valid); else n_pass++;
        if (if_rdata !== 32'h2008_0005) $display("FAIL sf_if_rdata got %h want 20080005", if_rdata); else n_pass++;
        if (mem_req !== 1'b0) $display("FAIL sf_mem_req_done got %b want 0", mem_req); else n_pass++;
        if (stall_if !== 1'b0) $display("FAIL sf_stall_c2 got %b want 0", stall_if); else n_pass++;
        if_req = 1'b0;
        cyc();
        n_checks++; if (if_valid !== 1'b0) $display("FAIL sf_if_valid_c3 got %b want 0", if_valid); else n_pass++;
    endtask

    task automatic test_simul_write();
        do_reset();
        if_req = 1'b1; if_addr = 32'h80;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        cyc();
        n_checks += 4;
        if (mem_req !== 1'b1) $display("FAIL sw_mem_req got %b want 1", mem_req); else n_pass++;
        if (mem_we !== 1'b1) $display("FAIL sw_mem_we got %b want 1", mem_we); else n_pass++;
        if (mem_addr !== 32'h100) $display("FAIL sw_mem_addr got %h want 100", mem_addr); else n_pass++;
        if (mem_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_mem_wdata got %h want deadbeef", mem_wdata); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        cyc();
        mem_ack = 1'b0;
        n_checks += 3;
        if (dm_valid !== 1'b1) $display("FAIL sw_dm_valid got %b want 1", dm_valid); else n_pass++;
        if (if_valid !== 1'b0) $display("FAIL sw_if_valid got %b want 0", if_valid); else n_pass++;
        if (dm_rdata !== '0) $display("FAIL sw_dm_rdata got %h want 0", dm_rdata); else n_pass++;
        dm_req = 1'b0;
        cyc();
        n_checks++; if (mem_req !== 1'b0) $display("FAIL sw_idle_gap got %b want 0", mem_req); else n_pass++;
        cyc();
        n_checks += 3;
        if (mem_req !== 1'b1) $display("FAIL sw_fetch_req got %b want 1", mem_req); else n_pass++;
        if (mem_we !== 1'b0) $display("FAIL sw_fetch_we got %b want 0", mem_we); else n_pass++;
        if (mem_addr !== 32'h80) $display("FAIL sw_fetch_addr got %h want 80", mem_addr); else n_pass++;
        mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
        cyc();
        mem_ack = 1'b0;
        n_checks += 3;
        if (if_valid !== 1'b1) $display("FAIL sw_if_valid2 got %b want 1", if_valid); else n_pass++;
        if (if_rdata !== 32'h1234) $display("FAIL sw_if_rdata got %h want 1234", if_rdata); else n_pass++;
        if (dm_rdata !== '0) $display("FAIL sw_dm_rdata_kept got %h want 0", dm_rdata); else n_pass++;
        if_req = 1'b0;
        cyc();
    endtask

    task automatic test_starvation();
        int model_starve = 0;
        int n_grants = 0;
        int n_fetch = 0;
        int got, want;
        do_reset();
        if_req = 1'b1; if_addr = 32'h4;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h8;
        for (int c = 0; c < 100 && n_grants < 10; c++) begin
            cyc();
            if (if_valid || dm_valid) begin
                got = dm_valid ? 1 : 0;
                if (model_starve == STARVE_MAX) begin want = 0; model_starve = 0; end
                else begin want = 1; model_starve++; end
                if (!dm_valid) n_fetch++;
                n_checks++;
                if (got !== want) $display("FAIL starve_order grant %0d got %s want %s", n_grants, got ? "D" : "F", want ? "D" : "F");
                else n_pass++;
                n_grants++;
            end
            mem_ack = mem_req;
        end
        n_checks += 2;
        if (n_grants != 10) $display("FAIL starve_timeout got %0d grants want 10", n_grants); else n_pass++;
        if (n_fetch != 2) $display("FAIL starve_fetch_count got %0d want 2", n_fetch); else n_pass++;
        do_reset();
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
        cyc();
        n_checks++; if (mem_req !== 1'b1) $display("FAIL rm_mem_req got %b want 1", mem_req); else n_pass++;
        reset = 1'b0; dm_req = 1'b0;
        cyc();
        n_checks += 2;
        if (mem_req !== 1'b0) $display("FAIL rm_req_drop got %b want 0", mem_req); else n_pass++;
        if (dm_valid !== 1'b0) $display("FAIL rm_no_valid got %b want 0", dm_valid); else n_pass++;
        reset = 1'b1;
        cyc();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        n_checks++; if (mem_req !== 1'b0) $display("FAIL rm_idle got %b want 0", mem_req); else n_pass++;
        cyc();
        mem_ack = 1'b0;
        n_checks += 3;
        if (dm_valid !== 1'b0) $display("FAIL rm_late_ack_valid got %b want 0", dm_valid); else n_pass++;
        if (dm_rdata !== '0) $display("FAIL rm_late_ack_rdata got %h want 0", dm_rdata); else n_pass++;
        if (mem_req !== 1'b0) $display("FAIL rm_late_ack_req got %b want 0", mem_req); else n_pass++;
    endtask

    task automatic test_mem_wait();
        int n_req = 0;
        int n_stall = 0;
        int valid_cyc = -1;
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_rdata = 32'hCAFE_0001;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) cyc();
            if (mem_req) n_req++;
            if (dm_valid) begin valid_cyc = c; dm_req = 1'b0; end
            mem_ack = (c == 5);
            #1;
            if (stall_dm) n_stall++;
        end
        mem_ack = 1'b0;
        n_checks += 6;
        if (n_req != 5) $display("FAIL mw_req_cycles got %0d want 5", n_req); else n_pass++;
        if (valid_cyc != 6) $display("FAIL mw_valid_cycle got %0d want 6", valid_cyc); else n_pass++;
        if (n_stall != 6) $display("FAIL mw_stall_cycles got %0d want 6", n_stall); else n_pass++;
        if (dm_rdata !== 32'hCAFE_0001) $display("FAIL mw_dm_rdata got %h want cafe0001", dm_rdata); else n_pass++;
        if (data_wait_cnt !== EXP_DWAIT) $display("FAIL mw_data_wait_cnt got %0d want %0d", data_wait_cnt, EXP_DWAIT); else n_pass++;
        if (fetch_wait_cnt !== '0) $display("FAIL mw_fetch_wait_cnt got %0d want 0", fetch_wait_cnt); else n_pass++;
    endtask

    // Model: an access granted in cycle g holds mem_req from g+1 through the
    // ack cycle k, pulses valid in k+1, and arbitration resumes at k+2.
    task automatic test_random();
        logic [31:0] phys [16];
        logic [31:0] refm [16];
        bit          act = 1'b0, done = 1'b0, chk = 1'b0, exp_iv, exp_dv;
        bit          new_act, new_done;
        int          owner = 0, wait_left = 0, starve = 0;
        logic [31:0] e_if = '0, e_dm = '0, pend = '0, g_addr = '0, g_wdata = '0;
        logic        g_we = 1'b0, p_we = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin phys[i] = $urandom; refm[i] = phys[i]; end
        for (int c = 0; c < 600; c++) begin
            if (c > 0) cyc();
            exp_iv = done && (owner == 0);
            exp_dv = done && (owner == 1);
            n_checks += 5;
            if (mem_req !== act) $display("FAIL rnd_mem_req c%0d got %b want %b", c, mem_req, act); else n_pass++;
            if (if_valid !== exp_iv) $display("FAIL rnd_if_valid c%0d got %b want %b", c, if_valid, exp_iv); else n_pass++;
            if (dm_valid !== exp_dv) $display("FAIL rnd_dm_valid c%0d got %b want %b", c, dm_valid, exp_dv); else n_pass++;
            if (if_rdata !== e_if) $display("FAIL rnd_if_rdata c%0d got %h want %h", c, if_rdata, e_if); else n_pass++;
            if (dm_rdata !== e_dm) $display("FAIL rnd_dm_rdata c%0d got %h want %h", c, dm_rdata, e_dm); else n_pass++;
            if (chk) begin
                n_checks += 2;
                if (mem_addr !== g_addr) $display("FAIL rnd_mem_addr c%0d got %h want %h", c, mem_addr, g_addr); else n_pass++;
                if (mem_we !== g_we) $display("FAIL rnd_mem_we c%0d got %b want %b", c, mem_we, g_we); else n_pass++;
                if (g_we) begin
                    n_checks++;
                    if (mem_wdata !== g_wdata) $display("FAIL rnd_mem_wdata c%0d got %h want %h", c, mem_wdata, g_wdata); else n_pass++;
                end
            end
            if (exp_iv) if_req = 1'b0;
            if (exp_dv) dm_req = 1'b0;
            if (!if_req && $urandom_range(0, 99) < 45) begin
                if_req = 1'b1; if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            end
            if (!dm_req && $urandom_range(0, 99) < 55) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; dm_wdata = $urandom;
            end
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (act) begin
                if (wait_left == 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) phys[mem_addr[5:2]] = mem_wdata;
                    else mem_rdata = phys[mem_addr[5:2]];
                end else wait_left--;
            end else if ($urandom_range(0, 3) == 0) mem_ack = 1'b1;
            #1;
            n_checks += 2;
            if (stall_if !== (if_req && !exp_iv)) $display("FAIL rnd_stall_if c%0d got %b want %b", c, stall_if, if_req && !exp_iv); else n_pass++;
            if (stall_dm !== (dm_req && !exp_dv)) $display("FAIL rnd_stall_dm c%0d got %b want %b", c, stall_dm, dm_req && !exp_dv); else n_pass++;
            new_act = act; new_done = 1'b0; chk = 1'b0;
            if (act && mem_ack) begin
                if (owner == 0) e_if = pend;
                else if (!p_we) e_dm = pend;
                new_act = 1'b0; new_done = 1'b1;
            end else if (!act && !done && (if_req || dm_req)) begin
                if (dm_req && !(if_req && starve == STARVE_MAX)) begin
                    owner = 1; starve = if_req ? starve + 1 : 0;
                    g_addr = dm_addr; g_we = dm_we; g_wdata = dm_wdata; p_we = dm_we;
                    if (dm_we) refm[dm_addr[5:2]] = dm_wdata;
                    else pend = refm[dm_addr[5:2]];
                end else begin
                    owner = 0; starve = 0;
                    g_addr = if_addr; g_we = 1'b0; p_we = 1'b0;
                    pend = refm[if_addr[5:2]];
                end
                new_act = 1'b1; chk = 1'b1; wait_left = $urandom_range(0, 3);
            end
            act = new_act; done = new_done;
        end
        if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simul_write();
        test_starvation();
        test_reset_mid_access();
        test_mem_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
